// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Brief    : State encoding, default parameters and helpers shared by the
//            FIR MAC sequencer and its tap counter.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int c_DEF_NTAPS  = 16;
    localparam int c_DEF_ADDR_W = 5;
    localparam int c_DEF_NCHAN  = 2;
    localparam int c_DEF_SETTLE = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap_counter.sv
`default_nettype none
// ============================================================================
// Module   : fir_tap_counter
// Brief    : Tap index plus settle sub-counter with terminal-count flags and
//            look-ahead outputs so the parent can register its decodes.
// Revision : 1.0 - initial release
// ============================================================================
module fir_tap_counter
    import fir_pkg::*;
#(
    parameter int NTAPS  = c_DEF_NTAPS,
    parameter int ADDR_W = c_DEF_ADDR_W,
    parameter int SETTLE = c_DEF_SETTLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              step,
    output logic [ADDR_W-1:0] tap_nxt,
    output logic              settle_tc,
    output logic              tap_tc,
    output logic              acc_nxt
);

    localparam int                c_SUB_W    = (clog2(SETTLE + 1) > 0) ? clog2(SETTLE + 1) : 1;
    localparam logic [c_SUB_W-1:0] c_SUB_LAST = c_SUB_W'(SETTLE);
    localparam logic [ADDR_W-1:0]  c_TAP_LAST = ADDR_W'(NTAPS - 1);

    logic [ADDR_W-1:0]  tap_q;
    logic [ADDR_W-1:0]  tap_d;
    logic [c_SUB_W-1:0] sub_q;
    logic [c_SUB_W-1:0] sub_d;

    assign settle_tc = (sub_q == c_SUB_LAST);
    assign tap_tc    = (tap_q == c_TAP_LAST);

    always_comb begin
        tap_d = tap_q;
        sub_d = sub_q;
        if (clr) begin
            tap_d = '0;
            sub_d = '0;
        end else if (step) begin
            if (settle_tc) begin
                sub_d = '0;
                // Wrapping to zero leaves the counter ready for the next channel.
                tap_d = tap_tc ? '0 : (tap_q + ADDR_W'(1));
            end else begin
                sub_d = sub_q + c_SUB_W'(1);
            end
        end
    end

    assign tap_nxt = tap_d;
    assign acc_nxt = (sub_d == c_SUB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tap_q <= '0;
            sub_q <= '0;
        end else begin
            tap_q <= tap_d;
            sub_q <= sub_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fir_mac_sequencer
// Brief    : Multi-channel FIR control sequencer: clears the accumulator,
//            walks all taps with programmable settle, then writes each result.
// Revision : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter  int NTAPS  = c_DEF_NTAPS,
    parameter  int ADDR_W = c_DEF_ADDR_W,
    parameter  int NCHAN  = c_DEF_NCHAN,
    parameter  int SETTLE = c_DEF_SETTLE,
    localparam int CH_W   = (NCHAN > 1) ? clog2(NCHAN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      ram_ptr,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic                   acc_zero,
    output logic                   acc_en,
    output logic                   da_we,
    output logic [CH_W-1:0]        da_chan,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [CH_W+ADDR_W-1:0] ram_addr,
    output logic                   ram_we
);

    localparam logic [CH_W-1:0] c_CHAN_LAST = CH_W'(NCHAN - 1);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic [CH_W-1:0]          chan_q, chan_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     overrun_q, overrun_d;
    logic                     acc_zero_q, acc_zero_d;
    logic                     acc_en_q, acc_en_d;
    logic                     da_we_q, da_we_d;
    logic [CH_W-1:0]          da_chan_q, da_chan_d;
    logic [ADDR_W-1:0]        rom_addr_q, rom_addr_d;
    logic [CH_W+ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                     ram_we_q, ram_we_d;

    logic                     last_chan;
    logic                     start_ok;
    logic [ADDR_W-1:0]        tap_nxt;
    logic                     settle_tc;
    logic                     tap_tc;
    logic                     acc_nxt;

    fir_tap_counter #(
        .NTAPS  (NTAPS),
        .ADDR_W (ADDR_W),
        .SETTLE (SETTLE)
    ) u_tap_counter (
        .clk       (clk),
        .reset     (reset),
        .clr       (state_q == ST_CLEAR),
        .step      (state_q == ST_MAC),
        .tap_nxt   (tap_nxt),
        .settle_tc (settle_tc),
        .tap_tc    (tap_tc),
        .acc_nxt   (acc_nxt)
    );

    always_comb begin
        last_chan = (chan_q == c_CHAN_LAST);
        state_d   = state_q;
        ptr_d     = ptr_q;
        chan_d    = chan_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        start_ok  = 1'b0;

        case (state_q)
            ST_IDLE:  start_ok = start;
            ST_CLEAR: state_d  = ST_MAC;
            ST_MAC: begin
                if (settle_tc && tap_tc) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_WRITE;
            ST_WRITE: begin
                if (!last_chan) begin
                    chan_d  = chan_q + CH_W'(1);
                    state_d = ST_CLEAR;
                end else begin
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                    // A start coinciding with the final write chains straight into the next pass.
                    start_ok = start;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_ok) begin
            state_d = ST_CLEAR;
            ptr_d   = ram_ptr;
            chan_d  = '0;
        end else if (start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        // Outputs are decoded from the next state so they line up with it once registered.
        busy_d     = (state_d != ST_IDLE);
        ram_we_d   = ~busy_d;
        acc_zero_d = (state_d == ST_CLEAR);
        acc_en_d   = (state_d == ST_MAC) && acc_nxt;
        da_we_d    = (state_d == ST_WRITE);
        da_chan_d  = da_we_d ? chan_d : da_chan_q;
        rom_addr_d = tap_nxt;
        ram_addr_d = {chan_d, ptr_d - tap_nxt};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            chan_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            acc_zero_q <= 1'b0;
            acc_en_q   <= 1'b0;
            da_we_q    <= 1'b0;
            da_chan_q  <= '0;
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            chan_q     <= chan_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            acc_zero_q <= acc_zero_d;
            acc_en_q   <= acc_en_d;
            da_we_q    <= da_we_d;
            da_chan_q  <= da_chan_d;
            rom_addr_q <= rom_addr_d;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign acc_zero = acc_zero_q;
    assign acc_en   = acc_en_q;
    assign da_we    = da_we_q;
    assign da_chan  = da_chan_q;
    assign rom_addr = rom_addr_q;
    assign ram_addr = ram_addr_q;
    assign ram_we   = ram_we_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Brief    : Directed self-checking bench for fir_mac_sequencer (default and
//            small SETTLE=0 / NTAPS=4 / NCHAN=1 configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [4:0] ptr1 = '0;
    logic [4:0] ptr2 = '0;

    logic       busy1, done1, ovr1, az1, ae1, dwe1, rwe1;
    logic [0:0] dch1;
    logic [4:0] rom1;
    logic [5:0] ram1;

    logic       busy2, done2, ovr2, az2, ae2, dwe2, rwe2;
    logic [0:0] dch2;
    logic [4:0] rom2;
    logic [5:0] ram2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer u_dut_def (
        .clk      (clk),
        .reset    (reset),
        .start    (start1),
        .ram_ptr  (ptr1),
        .busy     (busy1),
        .done     (done1),
        .overrun  (ovr1),
        .acc_zero (az1),
        .acc_en   (ae1),
        .da_we    (dwe1),
        .da_chan  (dch1),
        .rom_addr (rom1),
        .ram_addr (ram1),
        .ram_we   (rwe1)
    );

    fir_mac_sequencer #(
        .NTAPS  (4),
        .ADDR_W (5),
        .NCHAN  (1),
        .SETTLE (0)
    ) u_dut_small (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .ram_ptr  (ptr2),
        .busy     (busy2),
        .done     (done2),
        .overrun  (ovr2),
        .acc_zero (az2),
        .acc_en   (ae2),
        .da_we    (dwe2),
        .da_chan  (dch2),
        .rom_addr (rom2),
        .ram_addr (ram2),
        .ram_we   (rwe2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"},     32'(busy1), 0);
        chk({tag, " done"},     32'(done1), 0);
        chk({tag, " overrun"},  32'(ovr1),  0);
        chk({tag, " acc_zero"}, 32'(az1),   0);
        chk({tag, " acc_en"},   32'(ae1),   0);
        chk({tag, " da_we"},    32'(dwe1),  0);
        chk({tag, " da_chan"},  32'(dch1),  0);
        chk({tag, " rom_addr"}, 32'(rom1),  0);
        chk({tag, " ram_addr"}, 32'(ram1),  0);
        chk({tag, " ram_we"},   32'(rwe1),  1);
    endtask

    // Expected schedule for defaults: per channel 35 cycles = CLEAR, 32 MAC, DRAIN, WRITE.
    task automatic check_cycle(input int t, input int p, input int base, input int exp_done, input int exp_ovr);
        int q;
        int c;
        int k;
        bit acc;
        q   = p % 35;
        c   = p / 35;
        acc = (q >= 2) && (q <= 32) && (q % 2 == 0);
        chk($sformatf("busy@%0d", t),     32'(busy1), 1);
        chk($sformatf("ram_we@%0d", t),   32'(rwe1),  0);
        chk($sformatf("done@%0d", t),     32'(done1), exp_done);
        chk($sformatf("overrun@%0d", t),  32'(ovr1),  exp_ovr);
        chk($sformatf("acc_zero@%0d", t), 32'(az1),   (q == 0) ? 1 : 0);
        chk($sformatf("acc_en@%0d", t),   32'(ae1),   acc ? 1 : 0);
        chk($sformatf("da_we@%0d", t),    32'(dwe1),  (q == 34) ? 1 : 0);
        if (acc) begin
            k = (q - 2) / 2;
            chk($sformatf("rom_addr@%0d", t), 32'(rom1), k);
            chk($sformatf("ram_addr@%0d", t), 32'(ram1), (c << 5) | ((base - k) & 31));
        end
        if (q == 34) begin
            chk($sformatf("da_chan@%0d", t), 32'(dch1), c);
        end
    endtask

    // One full default pass; ovr_from is the first cycle overrun is expected high.
    task automatic run_pass(input string name, input int ptr0, input bit scramble,
                            input int late_t, input int ovr_from);
        int ae_c0;
        int ae_c1;
        ae_c0 = 0;
        ae_c1 = 0;
        ptr1   = 5'(ptr0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int t = 0; t < 70; t++) begin
            check_cycle(t, t, ptr0, 0, (t >= ovr_from) ? 1 : 0);
            if (ae1 === 1'b1) begin
                if (t < 35) ae_c0++;
                else        ae_c1++;
            end
            if (scramble) ptr1 = 5'($urandom_range(0, 31));
            start1 = (t == late_t);
            tick();
        end
        start1 = 1'b0;
        chk({name, " acc_en count ch0"}, ae_c0, 16);
        chk({name, " acc_en count ch1"}, ae_c1, 16);
        chk({name, " done@70"},    32'(done1), 1);
        chk({name, " busy@70"},    32'(busy1), 0);
        chk({name, " ram_we@70"},  32'(rwe1),  1);
        chk({name, " overrun@70"}, 32'(ovr1),  (70 >= ovr_from) ? 1 : 0);
        tick();
        chk({name, " done@71"}, 32'(done1), 0);
        chk({name, " busy@71"}, 32'(busy1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ram_exp[4];
        ram_exp = '{2, 1, 0, 31};

        // Reset state
        repeat (3) tick();
        chk_reset_vals("reset");
        #2 reset = 1'b0;
        tick();
        tick();
        chk_reset_vals("post-reset idle");

        // Basic pass with wrap below zero
        run_pass("basic", 5, 1'b0, -1000, 1000);

        // ram_ptr moving during the pass must not disturb addresses
        tick();
        run_pass("scramble", 9, 1'b1, -1000, 1000);

        // Late start during MAC: overrun, pass unaltered, no second pass
        tick();
        run_pass("late-start", 0, 1'b0, 20, 21);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy1 !== 1'b0) cnt++;
        end
        chk("late-start no second pass", cnt, 0);
        chk("late-start overrun sticky", 32'(ovr1), 1);

        // Clear overrun with an asynchronous reset pulse while idle
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        chk("reset clears overrun", 32'(ovr1), 0);

        // start held: back-to-back passes, done every 70 cycles, busy never drops
        ptr1   = 5'd7;
        start1 = 1'b1;
        tick();
        for (int t = 0; t < 140; t++) begin
            check_cycle(t, t % 70, 7, (t == 70) ? 1 : 0, (t >= 1) ? 1 : 0);
            tick();
        end
        chk("held done@140", 32'(done1), 1);
        chk("held busy@140", 32'(busy1), 1);
        chk("held clear@140", 32'(az1), 1);
        start1 = 1'b0;
        tick();
        cnt = 1;
        while (done1 !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("held final pass length", cnt, 70);
        tick();
        chk("held idle after drain", 32'(busy1), 0);

        // Asynchronous reset mid-MAC
        ptr1   = 5'd3;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (15) tick();
        chk("mid-mac busy before reset", 32'(busy1), 1);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals("async reset");
        #3 reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dwe1 !== 1'b0 || busy1 !== 1'b0) cnt++;
        end
        chk("no activity after abort", cnt, 0);
        run_pass("after-abort", 3, 1'b0, -1000, 1000);

        // Small configuration: SETTLE=0, NTAPS=4, NCHAN=1
        tick();
        ptr2   = 5'd2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("small busy@%0d", t),     32'(busy2), (t < 7) ? 1 : 0);
            chk($sformatf("small done@%0d", t),     32'(done2), (t == 7) ? 1 : 0);
            chk($sformatf("small acc_zero@%0d", t), 32'(az2),   (t == 0) ? 1 : 0);
            chk($sformatf("small acc_en@%0d", t),   32'(ae2),   (t >= 1 && t <= 4) ? 1 : 0);
            chk($sformatf("small da_we@%0d", t),    32'(dwe2),  (t == 6) ? 1 : 0);
            if (t >= 1 && t <= 4) begin
                chk($sformatf("small rom_addr@%0d", t), 32'(rom2), t - 1);
                chk($sformatf("small ram_addr@%0d", t), 32'(ram2), ram_exp[t-1]);
            end
            if (t == 6) begin
                chk("small da_chan", 32'(dch2), 0);
            end
            tick();
        end
        chk("small overrun", 32'(ovr2), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
